pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. Each cycle it decides the write-enable and flush of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, branch/jump redirects, instruction- and data-memory waits, and halt. It also keeps a saturating stall-cycle counter for performance debug. It sits beside the datapath and drives the WEN/flush pins of every pipeline register.

Parameters:
CNT_W, 32, width of the stall-cycle counter.
REG_W, 5, register-specifier width.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction fetch completes this cycle.
dhit  in  1  data access in MEM completes this cycle.
exmem_dmem_req  in  1  EX/MEM holds a load or store (dREN|dWEN).
idex_memread  in  1  instruction in EX is a load.
idex_rt  in  REG_W  load destination in EX.
ifid_rs  in  REG_W  rs of instruction in ID.
ifid_rt  in  REG_W  rt of instruction in ID.
ifid_uses_rt  in  1  ID instruction reads rt as a source.
redirect  in  1  branch taken or jump resolved (PC being redirected).
halt_mem  in  1  halt instruction is in MEM/WB.
pc_wen  out  1  PC update enable.
ifid_wen  out  1  IF/ID enable.
ifid_flush  out  1  IF/ID flush (bubble).
idex_wen  out  1  ID/EX enable.
idex_flush  out  1  ID/EX flush (clears control fields).
exmem_wen  out  1  EX/MEM enable.
memwb_wen  out  1  MEM/WB enable.
halted  out  1  core halted, sticky.
stall_cycles  out  CNT_W  cycles in which pc_wen was 0 outside HALT.

Behaviour:
- State register states: RUN, LOAD_STALL, MEM_WAIT, HALT. It resets asynchronously to RUN. stall_cycles and halted reset to 0.
- While nRST=0, every wen and flush output is 0.
- Enable and flush outputs are combinational (Mealy) from the state and current inputs, so they act in the same cycle. They are evaluated in the priority order below; the first matching rule wins.
  1. HALT: all wen=0, flushes=0, halted=1. HALT is left only by reset.
  2. Memory wait (exmem_dmem_req && !dhit): pc/ifid/idex/exmem/memwb wen=0, flushes=0. Next state is MEM_WAIT. MEM_WAIT re-evaluates the same rules each cycle and returns to RUN on the cycle dhit=1; in that cycle all wens are 1.
  3. Redirect: all wen=1, ifid_flush=1, idex_flush=1. A load-use hazard in the same cycle is ignored because the ID instruction is squashed.
  4. Load-use, checked only when state≠LOAD_STALL: idex_memread && idex_rt≠0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
     - pc_wen=0, ifid_wen=0, idex_flush=1, exmem_wen=1, memwb_wen=1.
     - Next state is LOAD_STALL, which lasts exactly one cycle and then returns to RUN.
  5. Fetch miss (!ihit): pc_wen=0, ifid_flush=1, all other wen=1.
  6. Otherwise: all wen=1, flushes=0.
- If halt_mem=1 in any non-HALT state, the next state is HALT. halt_mem takes priority over every other next-state cause, and the current-cycle outputs still follow the rules above.
- A flush asserted together with its wen: flush wins inside the pipeline register. The controller asserts wen=1 with every flush.
- stall_cycles increments on each rising edge where pc_wen=0 and state≠HALT. It saturates at all-ones and never wraps.
- Reset asserted mid-stall or mid-wait: the state returns to RUN immediately and the counter clears.

Decomposition:
- Shared package cpu_types_pkg: the hazard_state_t enum (RUN, LOAD_STALL, MEM_WAIT, HALT) and a REG_ZERO constant.
- Sub-module load_use_detect: purely combinational. It takes idex_memread, idex_rt, ifid_rs, ifid_rt and ifid_uses_rt, and returns the hazard bit.
- The top module holds the FSM, the priority mux and the counter.

Test Plan:
- Reset with nRST=0 for 2 cycles, then release with ihit=1 and no hazards: all wen=0 during reset; after release, all wen=1, stall_cycles=0, halted=0.
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 → one cycle of pc_wen=0, ifid_wen=0, idex_flush=1; next cycle (LOAD_STALL, inputs held) all wen=1; stall_cycles=1. Repeating with idex_rt=0 gives no stall.
- Data miss: exmem_dmem_req=1, dhit=0 for 3 cycles, then dhit=1 → all wen=0 for 3 cycles, all wen=1 on the dhit cycle, stall_cycles=3.
- Redirect with a simultaneous load-use hazard: redirect=1 → ifid_flush=1, idex_flush=1, pc_wen=1, no LOAD_STALL entry.
- Miss plus redirect: exmem_dmem_req=1, dhit=0, redirect=1 → freeze wins (no flush) until dhit=1, then the redirect flush is applied.
- Halt: halt_mem=1 for one cycle → from the next cycle halted=1 and all wen=0 indefinitely, stall_cycles frozen. Counter preloaded to all-ones via a forced stall sequence stays at all-ones.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the pipeline hazard controller
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        HALT       = 2'd3
    } hazard_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
module load_use_detect
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    output logic             hazard
);

    logic dest_live;
    logic rs_match;
    logic rt_match;

    // A load into the zero register never produces a value worth waiting for.
    assign dest_live = idex_memread && (idex_rt != REG_W'(REG_ZERO));
    assign rs_match  = (idex_rt == ifid_rs);
    assign rt_match  = ifid_uses_rt && (idex_rt == ifid_rt);
    assign hazard    = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dmem_req,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             redirect,
    input  logic             halt_mem,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    hazard_state_t state;
    hazard_state_t state_next;
    logic          load_use;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .idex_memread(idex_memread),
        .idex_rt     (idex_rt),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_uses_rt(ifid_uses_rt),
        .hazard      (load_use)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Priority mux: HALT, memory freeze, redirect, load-use, fetch miss, run.
    always_comb begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        ifid_flush = 1'b0;
        idex_wen   = 1'b0;
        idex_flush = 1'b0;
        exmem_wen  = 1'b0;
        memwb_wen  = 1'b0;
        state_next = state;
        if (nRST && (state != HALT)) begin
            if (exmem_dmem_req && !dhit) begin
                state_next = MEM_WAIT;
            end else if (redirect) begin
                pc_wen     = 1'b1;
                ifid_wen   = 1'b1;
                ifid_flush = 1'b1;
                idex_wen   = 1'b1;
                idex_flush = 1'b1;
                exmem_wen  = 1'b1;
                memwb_wen  = 1'b1;
                state_next = RUN;
            end else if (load_use && (state != LOAD_STALL)) begin
                idex_wen   = 1'b1;
                idex_flush = 1'b1;
                exmem_wen  = 1'b1;
                memwb_wen  = 1'b1;
                state_next = LOAD_STALL;
            end else if (!ihit) begin
                ifid_wen   = 1'b1;
                ifid_flush = 1'b1;
                idex_wen   = 1'b1;
                exmem_wen  = 1'b1;
                memwb_wen  = 1'b1;
                state_next = RUN;
            end else begin
                pc_wen     = 1'b1;
                ifid_wen   = 1'b1;
                idex_wen   = 1'b1;
                exmem_wen  = 1'b1;
                memwb_wen  = 1'b1;
                state_next = RUN;
            end
            if (halt_mem) begin
                state_next = HALT;
            end
        end
    end

    assign halted = (state == HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
        end else if (!pc_wen && (state != HALT) && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int REG_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit;
    logic             dhit;
    logic             exmem_dmem_req;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_uses_rt;
    logic             redirect;
    logic             halt_mem;
    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_flush;
    logic             exmem_wen;
    logic             memwb_wen;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    bit m_halt;
    bit m_ls;
    int m_cnt;

    pipeline_hazard_ctrl #(
        .CNT_W(CNT_W),
        .REG_W(REG_W)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .dhit          (dhit),
        .exmem_dmem_req(exmem_dmem_req),
        .idex_memread  (idex_memread),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .redirect      (redirect),
        .halt_mem      (halt_mem),
        .pc_wen        (pc_wen),
        .ifid_wen      (ifid_wen),
        .ifid_flush    (ifid_flush),
        .idex_wen      (idex_wen),
        .idex_flush    (idex_flush),
        .exmem_wen     (exmem_wen),
        .memwb_wen     (memwb_wen),
        .halted        (halted),
        .stall_cycles  (stall_cycles)
    );

    always #5 CLK = ~CLK;

    function automatic bit hazard_now();
        return idex_memread && (idex_rt != 0) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    endfunction

    // Expected {pc, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem, memwb}.
    function automatic logic [6:0] model_out();
        if (!nRST || m_halt)              return 7'b000_0000;
        if (exmem_dmem_req && !dhit)      return 7'b000_0000;
        if (redirect)                     return 7'b111_1111;
        if (hazard_now() && !m_ls)        return 7'b000_1111;
        if (!ihit)                        return 7'b011_1011;
        return 7'b110_1011;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        logic [6:0] e;
        bit         ls_next;
        @(negedge CLK);
        if (!nRST) begin
            m_halt = 1'b0;
            m_ls   = 1'b0;
            m_cnt  = 0;
        end
        e = model_out();
        chk({tag, ":en"}, 32'({pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
                               exmem_wen, memwb_wen}), 32'(e));
        chk({tag, ":halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ":cnt"}, 32'(stall_cycles), 32'(m_cnt));
        ls_next = !(exmem_dmem_req && !dhit) && !redirect && hazard_now() && !m_ls;
        @(posedge CLK);
        if (nRST && !m_halt) begin
            if (!e[6] && (m_cnt < CNT_MAX)) m_cnt++;
            m_ls = ls_next;
            if (halt_mem) m_halt = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; exmem_dmem_req = 1'b0; idex_memread = 1'b0;
        idex_rt = '0; ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
        redirect = 1'b0; halt_mem = 1'b0;
    endtask

    task automatic randomize_inputs();
        ihit           = ($urandom_range(3) != 0);
        dhit           = $urandom_range(1) != 0;
        exmem_dmem_req = ($urandom_range(9) < 3);
        idex_memread   = ($urandom_range(9) < 4);
        idex_rt        = REG_W'($urandom_range(3));
        ifid_rs        = REG_W'($urandom_range(3));
        ifid_rt        = REG_W'($urandom_range(3));
        ifid_uses_rt   = $urandom_range(1) != 0;
        redirect       = ($urandom_range(19) < 3);
        halt_mem       = 1'b0;
    endtask

    initial begin
        m_halt = 1'b0; m_ls = 1'b0; m_cnt = 0;
        idle();
        nRST = 1'b0;
        cycle("rst0");
        cycle("rst1");
        nRST = 1'b1;
        cycle("run");

        idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        cycle("lu");
        cycle("lu_hold");
        chk("lu_cnt", 32'(stall_cycles), 32'd1);
        idex_rt = 5'd0; ifid_rs = 5'd0;
        cycle("lu_r0");

        nRST = 1'b0;
        cycle("rst_mid");
        nRST = 1'b1;
        idle();
        exmem_dmem_req = 1'b1;
        repeat (3) cycle("miss");
        dhit = 1'b1;
        cycle("miss_done");
        chk("miss_cnt", 32'(stall_cycles), 32'd3);

        idle();
        idex_memread = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
        redirect = 1'b1;
        cycle("redir_lu");
        redirect = 1'b0; idex_memread = 1'b0;
        cycle("redir_after");

        idle();
        exmem_dmem_req = 1'b1; redirect = 1'b1;
        repeat (2) cycle("miss_redir");
        dhit = 1'b1;
        cycle("miss_redir_done");
        idle();
        cycle("settle");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            nRST = ($urandom_range(49) != 0);
            cycle("rand");
        end

        nRST = 1'b0;
        idle();
        cycle("rst_sat");
        nRST = 1'b1;
        ihit = 1'b0;
        repeat (20) cycle("sat");
        chk("sat_cnt", 32'(stall_cycles), 32'(CNT_MAX));
        halt_mem = 1'b1;
        cycle("halt_in");
        halt_mem = 1'b0;
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            cycle("halted");
        end
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_cnt", 32'(stall_cycles), 32'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
